// File: rtl/bram_array_ctrl.sv
// rtl/bram_array_ctrl.sv - BRAM array sequencer: Reset -> Write -> N x Read -> Stop, beat/tlast checking.
// Optional watchdog enabled by defining BRAM_CTRL_TIMEOUT_EN.
module bram_array_ctrl #(
  parameter int DEPTH_W   = 16,
  parameter int MAX_DEPTH = 4096,
  parameter int LOOP_W    = 8,
  parameter int TIMEOUT_W = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [DEPTH_W-1:0] cmd_depth,
  input  logic [LOOP_W-1:0]  cmd_loops,
  input  logic               cmd_abort,
  output logic               BRAM_en,
  output logic [1:0]         BRAM_Opts,
  output logic [DEPTH_W-1:0] BRAM_Depth,
  input  logic [1:0]         BRAM_Status,
  input  logic               wr_beat,
  input  logic               wr_last,
  input  logic               rd_beat,
  input  logic               rd_last,
  output logic               busy,
  output logic               done,
  output logic [1:0]         err,
  output logic               aborted,
  output logic [LOOP_W-1:0]  loops_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_WAIT_RST, S_WRITE, S_READ, S_REARM, S_STOP, S_DONE
  } state_t;

  localparam logic [DEPTH_W:0]  CNT_ONE  = {{DEPTH_W{1'b0}}, 1'b1};
  localparam logic [LOOP_W-1:0] LOOP_ONE = {{(LOOP_W-1){1'b0}}, 1'b1};
  localparam logic [31:0]       MAX_D32  = 32'(MAX_DEPTH);

  state_t              r_state, w_state_nxt;
  logic [DEPTH_W:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [DEPTH_W-1:0]  r_depth, w_depth_nxt;
  logic [LOOP_W-1:0]   r_loops, w_loops_nxt, r_loops_done, w_loops_done_nxt, w_loops_inc;
  logic [1:0]          r_err, w_err_nxt, r_opts, w_opts_nxt;
  logic                r_aborted, w_aborted_nxt, r_done, w_done_nxt, r_en, w_en_nxt;
  logic                w_accept, w_bad_depth, w_beat, w_last, w_beat_end, w_abortable, w_timeout;

  assign cmd_ready   = (r_state == S_IDLE) & ~rst;
  assign busy        = (r_state != S_IDLE);
  assign BRAM_en     = r_en;
  assign BRAM_Opts   = r_opts;
  assign BRAM_Depth  = r_depth;
  assign done        = r_done;
  assign err         = r_err;
  assign aborted     = r_aborted;
  assign loops_done  = r_loops_done;

  assign w_accept    = cmd_valid & cmd_ready;
  assign w_bad_depth = (cmd_depth == '0) || (32'(cmd_depth) > MAX_D32);
  assign w_beat      = (r_state == S_WRITE) ? wr_beat : (r_state == S_READ) ? rd_beat : 1'b0;
  assign w_last      = (r_state == S_WRITE) ? wr_last : rd_last;
  assign w_cnt_inc   = r_cnt + CNT_ONE;
  assign w_beat_end  = (w_cnt_inc == {1'b0, r_depth});
  assign w_loops_inc = r_loops_done + LOOP_ONE;
  assign w_abortable = (r_state inside {S_RST, S_WAIT_RST, S_WRITE, S_READ, S_REARM});

`ifdef BRAM_CTRL_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_wdog;
  logic                 w_watched;
  assign w_watched = (r_state inside {S_WAIT_RST, S_WRITE, S_READ, S_REARM, S_STOP});
  assign w_timeout = w_watched & (&r_wdog);

  always_ff @(posedge clk) begin
    if (rst || (w_state_nxt != r_state) || wr_beat || rd_beat)
      r_wdog <= '0;
    else if (w_watched && !(&r_wdog))
      r_wdog <= r_wdog + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  end
`else
  assign w_timeout = &{TIMEOUT_W{1'b0}};
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_depth_nxt      = r_depth;
    w_loops_nxt      = r_loops;
    w_loops_done_nxt = r_loops_done;
    w_err_nxt        = r_err;
    w_aborted_nxt    = r_aborted;
    w_done_nxt       = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_aborted_nxt = 1'b0;
        if (w_bad_depth) begin
          w_err_nxt  = 2'b01;
          w_done_nxt = 1'b1;
        end else begin
          w_err_nxt        = 2'b00;
          w_depth_nxt      = cmd_depth;
          w_loops_nxt      = cmd_loops;
          w_loops_done_nxt = '0;
          w_cnt_nxt        = '0;
          w_state_nxt      = S_RST;
        end
      end
      S_RST:      w_state_nxt = S_WAIT_RST;
      S_WAIT_RST: if (BRAM_Status == 2'b01) w_state_nxt = S_WRITE;
      S_WRITE, S_READ: if (w_beat) begin
        w_cnt_nxt = w_cnt_inc;
        if (w_last != w_beat_end) begin
          if (r_err == 2'b00) w_err_nxt = 2'b10;
          w_state_nxt = S_STOP;
        end else if (w_beat_end) begin
          w_cnt_nxt = '0;
          if (r_state == S_WRITE) begin
            w_state_nxt = (r_loops != '0) ? S_READ : S_STOP;
          end else begin
            w_loops_done_nxt = w_loops_inc;
            w_state_nxt      = (w_loops_inc == r_loops) ? S_STOP : S_REARM;
          end
        end
      end
      S_REARM: w_state_nxt = S_READ;
      S_STOP:  if (BRAM_Status == 2'b01) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Watchdog expiry: STOP goes straight to DONE since the array is not answering.
    if (w_timeout) begin
      if (r_err == 2'b00) w_err_nxt = 2'b11;
      w_state_nxt = (r_state == S_STOP) ? S_DONE : S_STOP;
    end

    // Abort overrides pass completion and tlast checks, but the beat itself is counted.
    if (w_abortable && cmd_abort) begin
      w_aborted_nxt    = 1'b1;
      w_state_nxt      = S_STOP;
      w_err_nxt        = r_err;
      w_loops_done_nxt = r_loops_done;
      w_cnt_nxt        = w_beat ? w_cnt_inc : r_cnt;
    end

    if (w_state_nxt == S_DONE) w_done_nxt = 1'b1;
  end

  always_comb begin
    w_opts_nxt = 2'b11;
    case (w_state_nxt)
      S_RST:   w_opts_nxt = 2'b00;
      S_WRITE: w_opts_nxt = 2'b01;
      S_READ:  w_opts_nxt = 2'b10;
      default: w_opts_nxt = 2'b11;
    endcase
    w_en_nxt = (w_state_nxt inside {S_RST, S_WAIT_RST, S_WRITE, S_READ, S_REARM, S_STOP});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_depth      <= '0;
      r_loops      <= '0;
      r_loops_done <= '0;
      r_err        <= 2'b00;
      r_aborted    <= 1'b0;
      r_done       <= 1'b0;
      r_en         <= 1'b0;
      r_opts       <= 2'b11;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_depth      <= w_depth_nxt;
      r_loops      <= w_loops_nxt;
      r_loops_done <= w_loops_done_nxt;
      r_err        <= w_err_nxt;
      r_aborted    <= w_aborted_nxt;
      r_done       <= w_done_nxt;
      r_en         <= w_en_nxt;
      r_opts       <= w_opts_nxt;
    end
  end

endmodule

// File: tb/tb_bram_array_ctrl.sv
// tb/tb_bram_array_ctrl.sv - directed self-checking bench for bram_array_ctrl
module tb_bram_array_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_depth = '0;
  logic [7:0]  cmd_loops = '0;
  logic        cmd_abort = 1'b0;
  logic        BRAM_en;
  logic [1:0]  BRAM_Opts;
  logic [15:0] BRAM_Depth;
  logic [1:0]  BRAM_Status = 2'b01;
  logic        wr_beat = 1'b0, wr_last = 1'b0, rd_beat = 1'b0, rd_last = 1'b0;
  logic        busy, done, aborted;
  logic [1:0]  err;
  logic [7:0]  loops_done;

  int total = 0;
  int bad = 0;
  logic hold_status = 1'b0;
  logic [13:0] rec_log;
  logic [1:0]  rec_last;
  int          rec_n;

  bram_array_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_depth(cmd_depth), .cmd_loops(cmd_loops), .cmd_abort(cmd_abort),
    .BRAM_en(BRAM_en), .BRAM_Opts(BRAM_Opts), .BRAM_Depth(BRAM_Depth),
    .BRAM_Status(BRAM_Status), .wr_beat(wr_beat), .wr_last(wr_last),
    .rd_beat(rd_beat), .rd_last(rd_last), .busy(busy), .done(done),
    .err(err), .aborted(aborted), .loops_done(loops_done)
  );

  always #5 clk = ~clk;

  // Array model: Reset->RST, idle/stop->WAITING, write->WRITING, read->READING, one cycle late.
  always @(posedge clk) begin
    if (hold_status) BRAM_Status <= 2'b00;
    else case (BRAM_Opts)
      2'b00:   BRAM_Status <= 2'b00;
      2'b01:   BRAM_Status <= 2'b10;
      2'b10:   BRAM_Status <= 2'b11;
      default: BRAM_Status <= 2'b01;
    endcase
  end

  // Log of distinct BRAM_Opts values while a command is in flight.
  always @(negedge clk) begin
    if (!busy) begin
      rec_log  <= '0;
      rec_last <= 2'b11;
      rec_n    <= 0;
    end else if (BRAM_Opts !== rec_last) begin
      rec_log  <= {rec_log[11:0], BRAM_Opts};
      rec_last <= BRAM_Opts;
      rec_n    <= rec_n + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [15:0] d, input logic [7:0] l);
    cmd_valid = 1'b1;
    cmd_depth = d;
    cmd_loops = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_opts(input logic [1:0] v, input string tag);
    int n = 0;
    while (BRAM_Opts !== v && n < 200) begin
      tick();
      n++;
    end
    chk(tag, BRAM_Opts, v);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, done, 1);
  endtask

  task automatic wr_burst(input int n, input int last_at);
    for (int i = 1; i <= n; i++) begin
      wr_beat = 1'b1;
      wr_last = (i == last_at);
      tick();
    end
    wr_beat = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic rd_burst(input int n, input int last_at);
    for (int i = 1; i <= n; i++) begin
      rd_beat = 1'b1;
      rd_last = (i == last_at);
      tick();
    end
    rd_beat = 1'b0;
    rd_last = 1'b0;
  endtask

  initial begin
    int    seen_done;
    logic [15:0] bad_d [3];
    bad_d[0] = 16'd0;
    bad_d[1] = 16'd4097;
    bad_d[2] = 16'd5000;

    // Reset state
    tick();
    tick();
    chk("rst_en", BRAM_en, 0);
    chk("rst_opts", BRAM_Opts, 2'b11);
    chk("rst_depth", BRAM_Depth, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_loops_done", loops_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready_in_rst", cmd_ready, 0);
    rst = 1'b0;
    tick();
    chk("idle_cmd_ready", cmd_ready, 1);

    // Full run: depth 8, two read passes; stray beat in RST must be ignored
    send_cmd(16'd8, 8'd2);
    chk("t1_en", BRAM_en, 1);
    chk("t1_opts_rst", BRAM_Opts, 2'b00);
    chk("t1_depth", BRAM_Depth, 8);
    chk("t1_busy", busy, 1);
    chk("t1_cmd_ready", cmd_ready, 0);
    wr_burst(1, 1);
    chk("t1_opts_wait", BRAM_Opts, 2'b11);
    wait_opts(2'b01, "t1_to_write");
    wr_burst(8, 8);
    chk("t1_opts_read", BRAM_Opts, 2'b10);
    rd_burst(8, 8);
    chk("t1_opts_rearm", BRAM_Opts, 2'b11);
    chk("t1_loops_mid", loops_done, 1);
    wait_opts(2'b10, "t1_read2");
    rd_burst(8, 8);
    chk("t1_opts_stop", BRAM_Opts, 2'b11);
    wait_done("t1_done");
    chk("t1_err", err, 0);
    chk("t1_aborted", aborted, 0);
    chk("t1_loops_done", loops_done, 2);
    chk("t1_en_done", BRAM_en, 0);
    chk("t1_opts_n", rec_n, 7);
    chk("t1_opts_seq", rec_log, 14'b00_11_01_10_11_10_11);
    tick();
    chk("t1_done_pulse", done, 0);
    chk("t1_idle_ready", cmd_ready, 1);

    // Out-of-range depths rejected with a done pulse one cycle after accept
    for (int k = 0; k < 3; k++) begin
      send_cmd(bad_d[k], 8'd1);
      chk($sformatf("bad%0d_done", k), done, 1);
      chk($sformatf("bad%0d_err", k), err, 2'b01);
      chk($sformatf("bad%0d_en", k), BRAM_en, 0);
      chk($sformatf("bad%0d_busy", k), busy, 0);
      tick();
      chk($sformatf("bad%0d_done_off", k), done, 0);
      chk($sformatf("bad%0d_en2", k), BRAM_en, 0);
    end

    // Early wr_last on 3rd of 4 beats
    send_cmd(16'd4, 8'd1);
    chk("t3_err_cleared", err, 0);
    wait_opts(2'b01, "t3_to_write");
    wr_burst(3, 3);
    chk("t3_opts_stop", BRAM_Opts, 2'b11);
    chk("t3_err_now", err, 2'b10);
    wait_done("t3_done");
    chk("t3_err", err, 2'b10);
    chk("t3_loops_done", loops_done, 0);
    tick();

    // Missing wr_last on final beat, write-only command
    send_cmd(16'd2, 8'd0);
    wait_opts(2'b01, "t3b_to_write");
    wr_burst(2, 0);
    wait_done("t3b_done");
    chk("t3b_err", err, 2'b10);
    tick();

    // Write-only command completes cleanly
    send_cmd(16'd2, 8'd0);
    wait_opts(2'b01, "t3c_to_write");
    wr_burst(2, 2);
    chk("t3c_opts_stop", BRAM_Opts, 2'b11);
    wait_done("t3c_done");
    chk("t3c_err", err, 0);
    chk("t3c_loops_done", loops_done, 0);
    tick();

    // Abort in 2nd read pass together with a beat; STOP waits for WAITING
    send_cmd(16'd4, 8'd3);
    wait_opts(2'b01, "t4_to_write");
    wr_burst(4, 4);
    rd_burst(4, 4);
    wait_opts(2'b10, "t4_read2");
    rd_burst(2, 0);
    rd_beat = 1'b1;
    cmd_abort = 1'b1;
    hold_status = 1'b1;
    tick();
    rd_beat = 1'b0;
    cmd_abort = 1'b0;
    chk("t4_opts_stop", BRAM_Opts, 2'b11);
    chk("t4_aborted_now", aborted, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("t4_stop_held_busy", busy, 1);
    chk("t4_stop_held_done", done, 0);
    hold_status = 1'b0;
    wait_done("t4_done");
    chk("t4_aborted", aborted, 1);
    chk("t4_err", err, 0);
    chk("t4_loops_done", loops_done, 1);
    tick();

    // Largest legal depth accepted, aborted straight out of RST
    send_cmd(16'd4096, 8'd1);
    chk("t4b_busy", busy, 1);
    chk("t4b_depth", BRAM_Depth, 4096);
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    wait_done("t4b_done");
    chk("t4b_aborted", aborted, 1);
    chk("t4b_err", err, 0);
    tick();

    // rst pulsed mid-READ
    send_cmd(16'd4, 8'd1);
    wait_opts(2'b01, "t5_to_write");
    wr_burst(4, 4);
    rd_burst(2, 0);
    rst = 1'b1;
    tick();
    chk("t5_en", BRAM_en, 0);
    chk("t5_opts", BRAM_Opts, 2'b11);
    chk("t5_busy", busy, 0);
    chk("t5_depth", BRAM_Depth, 0);
    chk("t5_aborted", aborted, 0);
    rst = 1'b0;
    #1;
    chk("t5_cmd_ready", cmd_ready, 1);
    seen_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) seen_done++;
      tick();
    end
    chk("t5_no_done", seen_done, 0);

    // Clean run after reset
    send_cmd(16'd2, 8'd1);
    wait_opts(2'b01, "t6_to_write");
    wr_burst(2, 2);
    rd_burst(2, 2);
    wait_done("t6_done");
    chk("t6_err", err, 0);
    chk("t6_loops_done", loops_done, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
